// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the RV64I multicycle control unit: FSM states, opcodes,
// rd-source selects and ALU function codes.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH, DECODE, EXEC, MEM, WB, BRANCH, TRAP
  } state_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [1:0] RD_MEM = 2'd0;
  localparam logic [1:0] RD_IMM = 2'd1;
  localparam logic [1:0] RD_ALU = 2'd2;
  localparam logic [1:0] RD_PC4 = 2'd3;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SR  = 3'b101;

  // Branch func3 010/011 have no comparison encoding and are treated as illegal.
  function automatic logic insn_legal(logic [6:0] opc, logic [2:0] f3);
    case (opc)
      OPC_OP, OPC_IMM, OPC_LOAD, OPC_STORE, OPC_LUI,
      OPC_AUIPC, OPC_JAL, OPC_JALR: insn_legal = 1'b1;
      OPC_BRANCH:                   insn_legal = (f3[2:1] != 2'b01);
      default:                      insn_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch resolution from the registered {eq, ls, lu} flags; func3[0] inverts.
module branch_cond (
  input  logic [2:0] func3,
  input  logic [2:0] flags,
  output logic       taken
);
  logic base;

  always_comb begin
    base = 1'b0;
    case (func3[2:1])
      2'b00:   base = flags[2];
      2'b10:   base = flags[1];
      2'b11:   base = flags[0];
      default: base = 1'b0;
    endcase
    taken = base ^ func3[0];
  end
endmodule

// File: rtl/control_unit.sv
// Multicycle sequencer for the RV64I datapath: fetch, decode and a fixed FSM
// driving every strobe and select; outputs are combinational from state and IR.
module control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter state_t ResetState = FETCH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] insn,
  input  logic [2:0]  flags_value,
  output logic        load_ins,
  output logic        load_imm,
  output logic        load_rs1,
  output logic        load_rs2,
  output logic        load_alu,
  output logic        load_flags,
  output logic        load_pc_alu,
  output logic        load_data_memory,
  output logic        load_regfile,
  output logic        load_pc,
  output logic        write_mem,
  output logic        sel_pc_next,
  output logic        sel_pc_alu,
  output logic        sel_alu_a,
  output logic        sel_alu_b,
  output logic [1:0]  sel_rd,
  output logic [1:0]  sel_mem_size,
  output logic [2:0]  sel_mem_extension,
  output logic [2:0]  func3,
  output logic        sub_sra,
  output logic [4:0]  rd_addr,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  output logic        insn_done,
  output logic        illegal
);
  state_t     state, state_next;
  logic [6:0] opc;
  logic [2:0] f3;
  logic       taken;
  logic       unused_insn_bits;

  assign opc              = insn[6:0];
  assign f3               = insn[14:12];
  assign rd_addr          = insn[11:7];
  assign rs1_addr         = insn[19:15];
  assign rs2_addr         = insn[24:20];
  assign unused_insn_bits = ^{insn[31], insn[29:25]};

  branch_cond u_branch_cond (
    .func3 (f3),
    .flags (flags_value),
    .taken (taken)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ResetState;
    else       state <= state_next;
  end

  always_comb begin
    state_next        = state;
    load_ins          = 1'b0;
    load_imm          = 1'b0;
    load_rs1          = 1'b0;
    load_rs2          = 1'b0;
    load_alu          = 1'b0;
    load_flags        = 1'b0;
    load_pc_alu       = 1'b0;
    load_data_memory  = 1'b0;
    load_regfile      = 1'b0;
    load_pc           = 1'b0;
    write_mem         = 1'b0;
    sel_pc_next       = 1'b0;
    sel_pc_alu        = 1'b0;
    sel_alu_a         = 1'b0;
    sel_alu_b         = 1'b0;
    sel_rd            = RD_MEM;
    sel_mem_size      = 2'b00;
    sel_mem_extension = 3'b000;
    func3             = ALU_ADD;
    sub_sra           = 1'b0;
    insn_done         = 1'b0;
    illegal           = 1'b0;

    // Reset blanks every control output so an in-flight instruction cannot write.
    if (!reset) begin
      case (state)
        FETCH: begin
          load_ins   = 1'b1;
          state_next = DECODE;
        end
        DECODE: begin
          load_imm    = 1'b1;
          load_rs1    = 1'b1;
          load_rs2    = 1'b1;
          load_pc_alu = 1'b1;
          if (!insn_legal(opc, f3)) state_next = TRAP;
          else if (opc == OPC_LUI)  state_next = WB;
          else                      state_next = EXEC;
        end
        EXEC: begin
          load_alu   = 1'b1;
          state_next = WB;
          case (opc)
            OPC_OP: begin
              func3   = f3;
              sub_sra = insn[30];
            end
            OPC_IMM: begin
              sel_alu_b = 1'b1;
              func3     = f3;
              sub_sra   = (f3 == ALU_SR) && insn[30];
            end
            OPC_LOAD, OPC_STORE: begin
              sel_alu_b  = 1'b1;
              state_next = MEM;
            end
            OPC_AUIPC, OPC_JAL: begin
              sel_alu_a = 1'b1;
              sel_alu_b = 1'b1;
            end
            OPC_JALR: sel_alu_b = 1'b1;
            OPC_BRANCH: begin
              load_alu   = 1'b0;
              load_flags = 1'b1;
              sub_sra    = 1'b1;
              state_next = BRANCH;
            end
            default: begin
              load_alu   = 1'b0;
              state_next = TRAP;
            end
          endcase
        end
        MEM: begin
          sel_mem_size = insn[13:12];
          if (opc == OPC_STORE) begin
            write_mem  = 1'b1;
            load_pc    = 1'b1;
            insn_done  = 1'b1;
            state_next = FETCH;
          end else begin
            load_data_memory = 1'b1;
            state_next       = WB;
          end
        end
        WB: begin
          load_regfile = (rd_addr != 5'd0);
          load_pc      = 1'b1;
          insn_done    = 1'b1;
          state_next   = FETCH;
          case (opc)
            OPC_LOAD: begin
              sel_rd            = RD_MEM;
              sel_mem_extension = f3;
            end
            OPC_LUI: sel_rd = RD_IMM;
            OPC_JAL, OPC_JALR: begin
              sel_rd      = RD_PC4;
              sel_pc_next = 1'b1;
            end
            default: sel_rd = RD_ALU;
          endcase
        end
        BRANCH: begin
          load_pc    = 1'b1;
          sel_pc_alu = taken;
          insn_done  = 1'b1;
          state_next = FETCH;
        end
        TRAP: illegal = 1'b1;
        default: state_next = ResetState;
      endcase
    end
  end
endmodule

// File: tb/tb_control_unit.sv
// Scoreboarded bench for control_unit: each instruction pushes its expected
// per-cycle control word, and the drain loop drives inputs and compares.
module tb_control_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] insn = '0;
  logic [2:0]  flags_value = '0;
  logic load_ins, load_imm, load_rs1, load_rs2, load_alu, load_flags, load_pc_alu;
  logic load_data_memory, load_regfile, load_pc, write_mem;
  logic sel_pc_next, sel_pc_alu, sel_alu_a, sel_alu_b;
  logic [1:0] sel_rd, sel_mem_size;
  logic [2:0] sel_mem_extension, func3;
  logic sub_sra, insn_done, illegal;
  logic [4:0] rd_addr, rs1_addr, rs2_addr;

  typedef struct packed {
    logic load_ins, load_imm, load_rs1, load_rs2, load_alu, load_flags, load_pc_alu;
    logic load_data_memory, load_regfile, load_pc, write_mem;
    logic sel_pc_next, sel_pc_alu, sel_alu_a, sel_alu_b;
    logic [1:0] sel_rd, sel_mem_size;
    logic [2:0] sel_mem_extension, func3;
    logic sub_sra, insn_done, illegal;
    logic [4:0] rd_addr, rs1_addr, rs2_addr;
  } ctl_t;

  typedef struct {
    string       tag;
    logic        rst;
    logic [31:0] w;
    logic [2:0]  fl;
    ctl_t        exp;
  } step_t;

  step_t sbq[$];
  int    n_chk = 0;
  int    n_fail = 0;
  ctl_t  got;

  always #5 clk = ~clk;

  control_unit dut (
    .clk(clk), .reset(reset), .insn(insn), .flags_value(flags_value),
    .load_ins(load_ins), .load_imm(load_imm), .load_rs1(load_rs1), .load_rs2(load_rs2),
    .load_alu(load_alu), .load_flags(load_flags), .load_pc_alu(load_pc_alu),
    .load_data_memory(load_data_memory), .load_regfile(load_regfile), .load_pc(load_pc),
    .write_mem(write_mem), .sel_pc_next(sel_pc_next), .sel_pc_alu(sel_pc_alu),
    .sel_alu_a(sel_alu_a), .sel_alu_b(sel_alu_b), .sel_rd(sel_rd),
    .sel_mem_size(sel_mem_size), .sel_mem_extension(sel_mem_extension), .func3(func3),
    .sub_sra(sub_sra), .rd_addr(rd_addr), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .insn_done(insn_done), .illegal(illegal)
  );

  assign got = {load_ins, load_imm, load_rs1, load_rs2, load_alu, load_flags, load_pc_alu,
                load_data_memory, load_regfile, load_pc, write_mem,
                sel_pc_next, sel_pc_alu, sel_alu_a, sel_alu_b, sel_rd, sel_mem_size,
                sel_mem_extension, func3, sub_sra, insn_done, illegal,
                rd_addr, rs1_addr, rs2_addr};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic ctl_t base(input logic [31:0] w);
    ctl_t e;
    e = '0;
    e.rd_addr  = w[11:7];
    e.rs1_addr = w[19:15];
    e.rs2_addr = w[24:20];
    return e;
  endfunction

  task automatic push(input string tag, input logic rst, input logic [31:0] w,
                      input logic [2:0] fl, input ctl_t e);
    step_t s;
    s.tag = tag; s.rst = rst; s.w = w; s.fl = fl; s.exp = e;
    sbq.push_back(s);
  endtask

  task automatic push_reset(input int cycles, input logic [31:0] w);
    for (int i = 0; i < cycles; i++) push($sformatf("reset[%0d]", i), 1'b1, w, 3'b000, base(w));
  endtask

  // Reference sequencing, written from the instruction classes.
  task automatic expect_insn(input string name, input logic [31:0] w, input logic [2:0] fl);
    ctl_t       e;
    logic [6:0] op;
    logic [2:0] f3;
    logic       tk;
    op = w[6:0];
    f3 = w[14:12];

    e = base(w); e.load_ins = 1'b1;
    push({name, "/fetch"}, 1'b0, w, fl, e);
    e = base(w); e.load_imm = 1'b1; e.load_rs1 = 1'b1; e.load_rs2 = 1'b1; e.load_pc_alu = 1'b1;
    push({name, "/decode"}, 1'b0, w, fl, e);

    if (!(op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63}) ||
        (op == 7'h63 && (f3 == 3'b010 || f3 == 3'b011))) begin
      e = base(w); e.illegal = 1'b1;
      for (int i = 0; i < 10; i++) push($sformatf("%s/trap%0d", name, i), 1'b0, w, fl, e);
      return;
    end

    if (op != 7'h37) begin
      e = base(w); e.load_alu = 1'b1;
      case (op)
        7'h33: begin e.func3 = f3; e.sub_sra = w[30]; end
        7'h13: begin e.sel_alu_b = 1'b1; e.func3 = f3; e.sub_sra = (f3 == 3'b101) & w[30]; end
        7'h03, 7'h23, 7'h67: e.sel_alu_b = 1'b1;
        7'h17, 7'h6F: begin e.sel_alu_a = 1'b1; e.sel_alu_b = 1'b1; end
        7'h63: begin e.load_alu = 1'b0; e.load_flags = 1'b1; e.sub_sra = 1'b1; end
        default: ;
      endcase
      push({name, "/exec"}, 1'b0, w, fl, e);
    end

    if (op == 7'h23) begin
      e = base(w); e.write_mem = 1'b1; e.sel_mem_size = w[13:12];
      e.load_pc = 1'b1; e.insn_done = 1'b1;
      push({name, "/mem"}, 1'b0, w, fl, e);
      return;
    end
    if (op == 7'h03) begin
      e = base(w); e.load_data_memory = 1'b1; e.sel_mem_size = w[13:12];
      push({name, "/mem"}, 1'b0, w, fl, e);
    end
    if (op == 7'h63) begin
      case (f3)
        3'b000: tk = fl[2];
        3'b001: tk = ~fl[2];
        3'b100: tk = fl[1];
        3'b101: tk = ~fl[1];
        3'b110: tk = fl[0];
        default: tk = ~fl[0];
      endcase
      e = base(w); e.load_pc = 1'b1; e.sel_pc_alu = tk; e.insn_done = 1'b1;
      push({name, "/branch"}, 1'b0, w, fl, e);
      return;
    end

    e = base(w); e.load_regfile = (w[11:7] != 5'd0); e.load_pc = 1'b1; e.insn_done = 1'b1;
    case (op)
      7'h03: begin e.sel_rd = 2'd0; e.sel_mem_extension = f3; end
      7'h37: e.sel_rd = 2'd1;
      7'h6F, 7'h67: begin e.sel_rd = 2'd3; e.sel_pc_next = 1'b1; end
      default: e.sel_rd = 2'd2;
    endcase
    push({name, "/wb"}, 1'b0, w, fl, e);
  endtask

  initial begin
    step_t s;
    push_reset(2, 32'h0);
    expect_insn("addi",  32'h00700293, 3'b000);
    expect_insn("sub",   32'h402081B3, 3'b000);
    expect_insn("srai",  32'h4030D213, 3'b000);
    expect_insn("slli",  32'h00309213, 3'b000);
    expect_insn("lw",    32'h0080A303, 3'b000);
    expect_insn("sw",    32'h0020A223, 3'b000);
    expect_insn("beq",   32'h00208463, 3'b100);
    expect_insn("bne",   32'h00209463, 3'b100);
    expect_insn("bgeu",  32'h0020F463, 3'b001);
    expect_insn("blt",   32'h0020C463, 3'b010);
    expect_insn("lui",   32'h123453B7, 3'b000);
    expect_insn("auipc", 32'h00001417, 3'b000);
    expect_insn("jal",   32'h008000EF, 3'b000);
    expect_insn("jalr0", 32'h00008067, 3'b000);
    expect_insn("ill7f", 32'h0000007F, 3'b000);
    push_reset(2, 32'h0000007F);
    expect_insn("addi2", 32'h00700293, 3'b000);
    expect_insn("br010", 32'h0020A463, 3'b111);
    push_reset(1, 32'h0020A463);
    expect_insn("add0",  32'h00208033, 3'b000);

    @(negedge clk);
    while (sbq.size() > 0) begin
      s = sbq.pop_front();
      reset = s.rst;
      insn = s.w;
      flags_value = s.fl;
      #1;
      chk(s.tag, 64'(got), 64'(s.exp));
      @(negedge clk);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/control_unit.md
# control_unit

Multicycle sequencer for the RV64I datapath (`dataflow`). It fetches each instruction into the IR and decodes its opcode. It then walks a fixed state machine that drives every load strobe, mux select, ALU function and memory control of the datapath, one instruction at a time. It sits beside `dataflow` in the CPU top and observes only the IR contents and the registered ALU flags.

## Interface
Parameters:
- `ResetState`, default FETCH: state entered on reset (kept parameterised for bench bring-up only).

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high.
- `insn`  in  32  IR output from datapath.
- `flags_value`  in  3  registered {eq, ls, lu}.
- `load_ins, load_imm, load_rs1, load_rs2, load_alu, load_flags, load_pc_alu, load_data_memory, load_regfile, load_pc`  out  1 each  register load strobes.
- `write_mem`  out  1  data-memory write strobe.
- `sel_pc_next, sel_pc_alu, sel_alu_a, sel_alu_b`  out  1 each  datapath mux selects.
- `sel_rd`  out  2  rd source: 0 mem_extended, 1 imm, 2 alu, 3 pc_alu.
- `sel_mem_size`  out  2  access size (= insn[13:12]).
- `sel_mem_extension`  out  3  load extension (= insn[14:12]).
- `func3`  out  3  ALU function.
- `sub_sra`  out  1  ALU subtract / arithmetic-shift.
- `rd_addr, rs1_addr, rs2_addr`  out  5 each  = insn[11:7], insn[19:15], insn[24:20].
- `insn_done`  out  1  one-cycle pulse in the cycle PC is loaded (retire).
- `illegal`  out  1  sticky; high in TRAP.

## Operation
States: FETCH, DECODE, EXEC, MEM, WB, BRANCH, TRAP.

Unlisted strobes are 0 in every state. Unlisted selects are 0, and `func3` defaults to 000.

- **FETCH:** `load_ins`=1. Go to DECODE.
- **DECODE:** `load_imm`, `load_rs1`, `load_rs2` and `load_pc_alu`=1, with `sel_pc_alu`=0 (pc+4).
  - Legal opcodes: 0110011, 0010011, 0000011, 0100011, 0110111, 0010111, 1101111, 1100111, 1100011.
  - LUI goes directly to WB. Any illegal opcode goes to TRAP. Everything else goes to EXEC.
- **EXEC:** `load_alu`=1 in every case below.
  - OP: a=rs1, b=rs2, `func3`=insn[14:12], `sub_sra`=insn[30]. Go to WB.
  - OP-IMM: `sel_alu_b`=1, `func3`=insn[14:12], `sub_sra`=insn[30] only when func3=101, else 0. Go to WB.
  - LOAD/STORE: a=rs1, b=imm, add. Go to MEM.
  - AUIPC/JAL: `sel_alu_a`=1, `sel_alu_b`=1, add. Go to WB.
  - JALR: a=rs1, b=imm, add. Go to WB. Bit 0 of the target is not cleared; odd targets are out of scope.
  - BRANCH: a=rs1, b=rs2, `sub_sra`=1, and `load_flags`=1 instead of `load_alu`. Go to BRANCH.
- **MEM:**
  - Load: `load_data_memory`=1, `sel_mem_size`=insn[13:12]. Go to WB.
  - Store: `write_mem`=1, `sel_mem_size`=insn[13:12], `load_pc`=1 (pc+4), `insn_done`=1. Go to FETCH.
- **WB:** `load_regfile`=1, suppressed when rd=0. `load_pc`=1 and `insn_done`=1. Go to FETCH.
  - `sel_rd`: LOAD 0 (with `sel_mem_extension`=insn[14:12]), LUI 1, OP/OP-IMM/AUIPC 2, JAL/JALR 3.
  - PC source: JAL/JALR use `sel_pc_next`=1 (alu_value). All others use `sel_pc_next`=0, `sel_pc_alu`=0.
- **BRANCH:** taken is computed from `flags_value` by insn[14:12]:
  - 000 eq; 001 !eq; 100 ls; 101 !ls; 110 lu; 111 !lu. Codes 010 and 011 were already rejected to TRAP in DECODE.
  - Outputs: `load_pc`=1, `sel_pc_next`=0, `sel_pc_alu`=taken, `insn_done`=1. Go to FETCH.
- **TRAP:** all strobes 0, `illegal`=1. Held until `reset`.

## Timing
- **Reset:** while `reset` is high, every strobe and `insn_done` are forced to 0 and `illegal` is 0. The next state is `ResetState`.
  - Reset mid-instruction abandons it with no regfile or memory write in that cycle.
  - The PC register reset is handled by the datapath on the same `reset`.
- **Cycles per instruction:** LUI 3; OP, OP-IMM, AUIPC, JAL, JALR, BRANCH and STORE 4; LOAD 5.
- **Output class:** all outputs are combinational from state and `insn`. The datapath samples them on the next rising edge.
- **IR stability:** `insn` is stable from DECODE through retire, because `load_ins` is asserted only in FETCH.
- **Flags:** valid in BRANCH, having been registered at the end of EXEC.

## Structure
- Package `cpu_ctrl_pkg` holds:
  - the state enum;
  - opcode localparams;
  - `sel_rd` encodings (RD_MEM, RD_IMM, RD_ALU, RD_PC4);
  - ALU func3 constants (ALU_ADD=000).
- Sub-module `branch_cond` (combinational: func3 and flags in, taken out) is instantiated once.

## Test plan
- Reset held for 2 cycles, then released → all strobes are 0 during reset. `load_ins`=1 in the first cycle after release.
- `addi x5,x0,7` (0x00700293) → 4 cycles. In EXEC, `sel_alu_b`=1 and `func3`=000. In WB, `sel_rd`=2, `rd_addr`=5, `load_regfile`=1, and `insn_done` pulses.
- `sub x3,x1,x2` (0x402081B3) → EXEC has `sub_sra`=1. `srai` with insn[30]=1 gives `sub_sra`=1; `slli` gives 0.
- `lw x6,8(x1)` (0x0080A303) → 5 cycles. MEM has `sel_mem_size`=10. WB has `sel_mem_extension`=010 and `sel_rd`=0.
- `beq` with flags=100 → BRANCH has `sel_pc_alu`=1. `bne` with the same flags → `sel_pc_alu`=0. `bgeu` with lu=1 → not taken.
- Opcode 0x0000007F → TRAP with `illegal`=1 and no strobes for 10 cycles. After `reset`, `illegal`=0 and the FSM is back in FETCH.
- `sw` → `write_mem` asserted for exactly 1 cycle and `load_regfile` never asserted. `x0` as rd → `load_regfile` stays 0.
